// File: rtl/day_segment_decoder.sv
// rtl/day_segment_decoder.sv - settles seven-segment day patterns, decodes them and checks mon..sun ordering
module day_segment_decoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int LOCK_COUNT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    output logic [2:0] day,
    output logic       day_valid,
    output logic       day_strobe,
    output logic       bad_pattern,
    output logic       seq_error,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
    localparam logic [2:0] LOCK   = 3'(LOCK_COUNT);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [6:0] seg_q, last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic [2:0] day_q, day_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       bad_q, bad_d;
    logic       seqerr_q, seqerr_d;
    logic [7:0] err_q, err_d;
    logic [2:0] exp_q, exp_d;
    logic [2:0] mc_q, mc_d;

    logic       seg_changed;
    logic       accept;
    logic       legal;
    logic [2:0] dec;
    logic [2:0] dec_next;
    logic [2:0] mc_hunt;

    always_comb begin
        legal = 1'b1;
        dec   = 3'd0;
        case (seg_q)
            7'b0011101: dec = 3'd0;
            7'b0111110: dec = 3'd1;
            7'b1001111: dec = 3'd2;
            7'b0110111: dec = 3'd3;
            7'b0000110: dec = 3'd4;
            7'b1110000: dec = 3'd5;
            7'b1110110: dec = 3'd6;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        seg_changed = (seg != seg_q);
        if (seg_changed)
            cnt_d = 4'd1;
        else if (cnt_q >= STABLE)
            cnt_d = STABLE;
        else
            cnt_d = cnt_q + 4'd1;
        // first_q marks the single cycle the run counter has just reached STABLE
        first_d  = (cnt_d == STABLE) && (seg_changed || (cnt_q != STABLE));
        accept   = first_q && (seg_q != last_q);
        dec_next = (dec == 3'd6) ? 3'd0 : dec + 3'd1;
        mc_hunt  = ((mc_q == 3'd0) || (dec == exp_q)) ? mc_q + 3'd1 : 3'd1;

        state_d  = state_q;
        last_d   = last_q;
        day_d    = day_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        bad_d    = 1'b0;
        seqerr_d = 1'b0;
        exp_d    = exp_q;
        mc_d     = mc_q;
        err_d    = err_q;

        if (accept) begin
            last_d = seg_q;
            if (!legal) begin
                bad_d = 1'b1;
            end else begin
                day_d    = dec;
                valid_d  = 1'b1;
                strobe_d = 1'b1;
                exp_d    = dec_next;
                case (state_q)
                    HUNT: begin
                        mc_d = mc_hunt;
                        if (mc_hunt >= LOCK)
                            state_d = LOCKED;
                    end
                    LOCKED: begin
                        if (dec != exp_q) begin
                            seqerr_d = 1'b1;
                            mc_d     = 3'd1;
                            state_d  = HUNT;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        if ((bad_d || seqerr_d) && (err_q != 8'hFF))
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= 7'h00;
            cnt_q    <= 4'd0;
            first_q  <= 1'b0;
            last_q   <= 7'h7F;
            state_q  <= HUNT;
            day_q    <= 3'd0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            bad_q    <= 1'b0;
            seqerr_q <= 1'b0;
            err_q    <= 8'd0;
            exp_q    <= 3'd0;
            mc_q     <= 3'd0;
        end else begin
            seg_q    <= seg;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            state_q  <= state_d;
            day_q    <= day_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            bad_q    <= bad_d;
            seqerr_q <= seqerr_d;
            err_q    <= err_d;
            exp_q    <= exp_d;
            mc_q     <= mc_d;
        end
    end

    assign day         = day_q;
    assign day_valid   = valid_q;
    assign day_strobe  = strobe_q;
    assign bad_pattern = bad_q;
    assign seq_error   = seqerr_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_q;

endmodule

// File: tb/tb_day_segment_decoder.sv
// tb/tb_day_segment_decoder.sv - directed self-checking bench for day_segment_decoder
module tb_day_segment_decoder;

    localparam logic [6:0] MON = 7'b0011101;
    localparam logic [6:0] TUE = 7'b0111110;
    localparam logic [6:0] WED = 7'b1001111;
    localparam logic [6:0] THU = 7'b0110111;
    localparam logic [6:0] FRI = 7'b0000110;
    localparam logic [6:0] SAT = 7'b1110000;
    localparam logic [6:0] SUN = 7'b1110110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h00;
    logic [2:0] day;
    logic       day_valid, day_strobe, bad_pattern, seq_error, locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int n_strobe, n_bad, n_seq;
    int s_day[$];
    int s_lock[$];
    int s_seq[$];
    logic [6:0] pats [7];

    day_segment_decoder #(.STABLE_CYCLES(2), .LOCK_COUNT(2)) dut (
        .clk(clk), .rst(rst), .seg(seg), .day(day), .day_valid(day_valid),
        .day_strobe(day_strobe), .bad_pattern(bad_pattern), .seq_error(seq_error),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [6:0] p);
        seg = p;
        @(posedge clk);
        #1;
        if (day_strobe) begin
            n_strobe++;
            s_day.push_back(int'(day));
            s_lock.push_back(int'(locked));
            s_seq.push_back(int'(seq_error));
        end
        if (bad_pattern) n_bad++;
        if (seq_error) n_seq++;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        repeat (n) cyc(p);
    endtask

    task automatic clear_log();
        n_strobe = 0; n_bad = 0; n_seq = 0;
        s_day.delete(); s_lock.delete(); s_seq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(7'h00);
        cyc(7'h00);
        checks++;
        if ({day, day_valid, day_strobe, bad_pattern, seq_error, locked, err_count} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {day, day_valid, day_strobe, bad_pattern, seq_error, locked, err_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_accept();
        clear_log();
        cyc(MON);
        checks++;
        if (day_strobe !== 1'b0) begin errors++; $display("FAIL first_edge1_strobe: got %b expected 0", day_strobe); end
        cyc(MON);
        checks++;
        if (day_strobe !== 1'b0) begin errors++; $display("FAIL first_edge2_strobe: got %b expected 0", day_strobe); end
        cyc(MON);
        checks++;
        if ({day_strobe, day_valid, day} !== 5'b11_000) begin
            errors++; $display("FAIL first_edge3: strobe/valid/day got %b expected 11000", {day_strobe, day_valid, day});
        end
        hold(MON, 5);
        checks++;
        if (n_strobe != 1) begin errors++; $display("FAIL held_once: strobes %0d expected 1", n_strobe); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL first_locked: got %b expected 0", locked); end
    endtask

    task automatic test_sequence();
        rst = 1'b1;
        cyc(7'h00);
        rst = 1'b0;
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 7; i++)
                hold(pats[i], 4);
        checks++;
        if (n_strobe != 14) begin errors++; $display("FAIL seq_strobes: got %0d expected 14", n_strobe); end
        for (int k = 0; k < 14 && k < s_day.size(); k++) begin
            checks++;
            if (s_day[k] != k % 7) begin errors++; $display("FAIL seq_day[%0d]: got %0d expected %0d", k, s_day[k], k % 7); end
            checks++;
            if (s_lock[k] != ((k == 0) ? 0 : 1)) begin
                errors++; $display("FAIL seq_locked[%0d]: got %0d expected %0d", k, s_lock[k], (k == 0) ? 0 : 1);
            end
        end
        checks++;
        if (n_seq != 0 || err_count !== 8'd0) begin
            errors++; $display("FAIL seq_no_errors: seq %0d err_count %0d expected 0 0", n_seq, err_count);
        end
    endtask

    task automatic test_seq_error();
        hold(MON, 4); hold(TUE, 4); hold(WED, 4);
        checks++;
        if ({locked, day} !== 4'b1_010) begin errors++; $display("FAIL pre_wed_locked: locked/day got %b expected 1010", {locked, day}); end
        clear_log();
        hold(FRI, 3);
        checks++;
        if ({day_strobe, day, seq_error, locked} !== 6'b1_100_1_0) begin
            errors++; $display("FAIL fri_jump: strobe/day/seq/locked got %b expected 110010", {day_strobe, day, seq_error, locked});
        end
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL fri_err_count: got %0d expected 1", err_count); end
        cyc(FRI);
        hold(SAT, 4);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock_sat: got %b expected 1", locked); end
        hold(SUN, 4);
        checks++;
        if ({locked, err_count} !== 9'h101 || n_seq != 1) begin
            errors++; $display("FAIL relock_sun: locked %b err %0d seq pulses %0d expected 1 1 1", locked, err_count, n_seq);
        end
    endtask

    task automatic test_bad_pattern();
        clear_log();
        hold(7'h7F, 4);
        checks++;
        if (n_bad != 1 || n_strobe != 0) begin
            errors++; $display("FAIL bad_pulse: bad %0d strobes %0d expected 1 0", n_bad, n_strobe);
        end
        checks++;
        if ({day, err_count, locked} !== {3'd6, 8'd2, 1'b1}) begin
            errors++; $display("FAIL bad_state: day %0d err %0d locked %b expected 6 2 1", day, err_count, locked);
        end
    endtask

    task automatic test_glitch();
        hold(TUE, 4);
        checks++;
        if ({day, locked, err_count} !== {3'd1, 1'b0, 8'd3}) begin
            errors++; $display("FAIL tue_after_sun: day %0d locked %b err %0d expected 1 0 3", day, locked, err_count);
        end
        clear_log();
        cyc(WED);
        hold(TUE, 4);
        checks++;
        if (n_strobe != 0 || n_bad != 0 || n_seq != 0) begin
            errors++; $display("FAIL glitch_ignored: strobes %0d bad %0d seq %0d expected 0 0 0", n_strobe, n_bad, n_seq);
        end
        hold(MON, 3);
        clear_log();
        hold(TUE, 3); hold(WED, 3); hold(TUE, 3);
        checks++;
        if (n_strobe != 3) begin errors++; $display("FAIL bounce_strobes: got %0d expected 3", n_strobe); end
        if (n_strobe == 3) begin
            checks++;
            if (s_day[0] != 1 || s_day[1] != 2 || s_day[2] != 1) begin
                errors++; $display("FAIL bounce_days: got %0d %0d %0d expected 1 2 1", s_day[0], s_day[1], s_day[2]);
            end
            checks++;
            if (s_seq[0] != 0 || s_seq[1] != 0 || s_seq[2] != 1) begin
                errors++; $display("FAIL bounce_seq: got %0d %0d %0d expected 0 0 1", s_seq[0], s_seq[1], s_seq[2]);
            end
        end
        checks++;
        if ({locked, err_count} !== {1'b0, 8'd4}) begin
            errors++; $display("FAIL bounce_state: locked %b err %0d expected 0 4", locked, err_count);
        end
    endtask

    task automatic test_reset_mid();
        hold(7'h7F, 4);
        hold(WED, 4);
        checks++;
        if ({locked, err_count} !== {1'b1, 8'd5}) begin
            errors++; $display("FAIL pre_reset: locked %b err %0d expected 1 5", locked, err_count);
        end
        rst = 1'b1;
        cyc(WED);
        rst = 1'b0;
        checks++;
        if ({day, day_valid, day_strobe, bad_pattern, seq_error, locked, err_count} !== 16'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0000",
                               {day, day_valid, day_strobe, bad_pattern, seq_error, locked, err_count});
        end
        clear_log();
        cyc(WED);
        cyc(WED);
        checks++;
        if (n_strobe != 0) begin errors++; $display("FAIL post_reset_early: strobes %0d expected 0", n_strobe); end
        cyc(WED);
        checks++;
        if ({day_strobe, day_valid, day, locked} !== 6'b1_1_010_0) begin
            errors++; $display("FAIL post_reset_accept: strobe/valid/day/locked got %b expected 110100",
                               {day_strobe, day_valid, day, locked});
        end
    endtask

    task automatic test_err_saturation();
        clear_log();
        for (int i = 0; i < 130; i++) begin
            hold(7'h7F, 3);
            hold(7'h00, 3);
        end
        checks++;
        if (n_bad != 260) begin errors++; $display("FAIL sat_bad_pulses: got %0d expected 260", n_bad); end
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
    endtask

    initial begin
        pats[0] = MON; pats[1] = TUE; pats[2] = WED; pats[3] = THU;
        pats[4] = FRI; pats[5] = SAT; pats[6] = SUN;
        test_reset();
        test_first_accept();
        test_sequence();
        test_seq_error();
        test_bad_pattern();
        test_glitch();
        test_reset_mid();
        test_err_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/day_segment_decoder.md
Name: day_segment_decoder

Overview:
- Receive-side companion to the day-of-week seven-segment sequencer.
- Samples the seven segment lines A..G and waits for each pattern to settle. Decodes the settled pattern back to a day index (mon=0 .. sun=6).
- Tracks the mon→tue→…→sun→mon sequence and flags illegal patterns and out-of-order days.
- Used as an on-board self-check of the display path and as the bench monitor for the sequencer.

Parameters:
- STABLE_CYCLES, 2, number of consecutive identical samples required before a pattern is accepted (legal range 1..15).
- LOCK_COUNT, 2, number of consecutive in-sequence days required to enter LOCKED (legal range 1..7).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg  input  7  segment lines, seg[6]=A, seg[5]=B … seg[0]=G, 1 = segment on.
- day  output  3  last accepted day index, 0..6.
- day_valid  output  1  high once at least one legal pattern has been accepted since reset.
- day_strobe  output  1  one-cycle pulse when a new legal day is accepted.
- bad_pattern  output  1  one-cycle pulse when a settled pattern is not in the decode table.
- seq_error  output  1  one-cycle pulse when an accepted day is not the expected successor while LOCKED.
- locked  output  1  high in the LOCKED state.
- err_count  output  8  saturating count of bad_pattern plus seq_error events.

Behaviour:
- Reset values: day=0, day_valid=0, day_strobe=0, bad_pattern=0, seq_error=0, locked=0, err_count=0. Internally: seg_q=0, run counter=0, last_accepted=7'h7F (matches no legal pattern), FSM=HUNT, expected=0, match counter=0.
- Decode table, ABCDEFG → day:
  - 0011101 → 0 (mon)
  - 0111110 → 1 (tue)
  - 1001111 → 2 (wed)
  - 0110111 → 3 (thu)
  - 0000110 → 4 (fri)
  - 1110000 → 5 (sat)
  - 1110110 → 6 (sun)
  - Any other value is illegal.
- Input stage: seg is registered into seg_q every cycle.
- Run counter:
  - Resets to 1 when the new seg_q differs from the old seg_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept event: fires on the cycle the counter first reaches STABLE_CYCLES, and only if seg_q != last_accepted. It then sets last_accepted=seg_q.
  - A pattern held indefinitely is accepted once.
  - The same pattern reappearing after a different settled pattern is accepted again.
  - A glitch shorter than STABLE_CYCLES is ignored. If the lines return to the last accepted pattern afterwards, nothing fires.
- Outputs are registered from the accept event. Latency from the first clock edge sampling a held pattern to the strobe/flag being high is STABLE_CYCLES+1 edges.
- Illegal accept:
  - bad_pattern=1 for one cycle.
  - day, day_valid and the FSM are unchanged.
  - err_count increments.
- Legal accept with decoded index d:
  - day=d, day_valid=1, day_strobe=1 for one cycle.
  - Then the FSM acts (below).
- FSM, state HUNT:
  - On a legal accept: if the match counter is 0 or d==expected, the match counter increments; otherwise the match counter is set to 1.
  - In both cases expected=(d+1) mod 7.
  - When the match counter reaches LOCK_COUNT, go to LOCKED with locked=1 in the same update.
  - No seq_error is raised in HUNT.
- FSM, state LOCKED:
  - If d==expected: stay LOCKED and set expected=(d+1) mod 7.
  - If d!=expected: seq_error=1 for one cycle, err_count increments, go to HUNT with match counter=1, expected=(d+1) mod 7, locked=0.
  - Illegal patterns do not leave LOCKED.
- Wrap-around: after 6 (sun), expected=0 (mon).
- err_count saturates at 255. When bad_pattern and seq_error coincide (impossible by construction), count once.
- Reset asserted mid-operation: all state returns to reset values on the next edge. The first pattern after reset is always accepted as new.

Test Plan:
- Reset, then hold seg=0011101 with STABLE_CYCLES=2 → day_strobe high after edge 3 with day=0, day_valid=1. No further strobe while the pattern is held.
- Drive all 7 legal patterns in order, each held 4 cycles, twice around → 14 strobes with day 0..6, 0..6. locked rises on the 2nd strobe and stays high. seq_error never asserts and err_count=0.
- While LOCKED at day=2 (wed), present 0000110 (fri) → day_strobe with day=4 and seq_error pulse. locked=0 and err_count=1. Then present sat and sun → locked=1 again.
- Present 1111111 for 4 cycles → bad_pattern pulse, day unchanged, err_count+1, locked state unchanged.
- Present a one-cycle glitch 1001111 inside a held tue pattern → no strobe and no flags. Present tue→wed→tue, each held 3 cycles → three strobes (1, 2, 1) and seq_error on the second tue.
- Assert rst for one cycle while LOCKED with err_count=5 → all outputs 0 on the next cycle. The re-held current pattern then produces a fresh day_strobe after STABLE_CYCLES+1 edges.
